// File: rtl/adc_multi_channel_sampler.sv
// Round-robin XADC DRP read sequencer that averages 2^AVG_LOG2 reads per aux channel.
// Define ADC_DEADZONE_EN to snap averaged values near mid-scale to exactly mid-scale.
module adc_multi_channel_sampler #(
  parameter int         NUM_CH         = 2,
  parameter logic [6:0] BASE_ADDR      = 7'h16,
  parameter int         ADC_BITS       = 12,
  parameter int         AVG_LOG2       = 2,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         DEADZONE       = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  output logic [6:0]                 daddr_out,
  output logic                       den_out,
  input  logic [15:0]                do_in,
  input  logic                       drdy_in,
  output logic [NUM_CH*ADC_BITS-1:0] adc_out,
  output logic [NUM_CH-1:0]          sample_valid,
  output logic                       round_done,
  output logic                       timeout_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MID   = 2 ** (ADC_BITS - 1);

  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_READ = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUBLISH} state_t;

  state_t             state, state_next;
  logic [CH_W-1:0]    ch, ch_wrap;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [TMR_W-1:0]   tmr;
  logic [ADC_BITS-1:0] sample, avg, pub_val;
  logic               read_done, timed_out;

  assign sample  = do_in[15 -: ADC_BITS];
  assign ch_wrap = (ch == LAST_CH) ? '0 : ch + CH_W'(1);
  assign avg     = ADC_BITS'(acc >> AVG_LOG2);

  always_comb begin
    pub_val = avg;
`ifdef ADC_DEADZONE_EN
    if ((int'(avg) >= MID - DEADZONE) && (int'(avg) <= MID + DEADZONE))
      pub_val = ADC_BITS'(MID);
`endif
  end

  // drdy is only honoured in WAIT; an expired timer abandons the channel's whole average
  always_comb begin
    state_next = state;
    read_done  = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE:    if (en) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (drdy_in) begin
          read_done  = 1'b1;
          state_next = (cnt == LAST_READ) ? PUBLISH : ISSUE;
        end else if (tmr == TMR_LIMIT) begin
          timed_out  = 1'b1;
          state_next = en ? ISSUE : IDLE;
        end
      end
      PUBLISH: state_next = en ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ch           <= '0;
      cnt          <= '0;
      acc          <= '0;
      tmr          <= '0;
      adc_out      <= '0;
      sample_valid <= '0;
      round_done   <= 1'b0;
      timeout_err  <= 1'b0;
      daddr_out    <= BASE_ADDR;
      den_out      <= 1'b0;
    end else begin
      state        <= state_next;
      den_out      <= (state == ISSUE);
      sample_valid <= '0;
      round_done   <= 1'b0;

      if (state == ISSUE)
        daddr_out <= BASE_ADDR + 7'(ch);

      if ((state == WAIT) && !read_done && !timed_out)
        tmr <= tmr + TMR_W'(1);
      else
        tmr <= '0;

      if (read_done) begin
        acc <= acc + ACC_W'(sample);
        cnt <= cnt + CNT_W'(1);
      end

      if (timed_out) begin
        timeout_err <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
        ch          <= ch_wrap;
      end

      if (state == PUBLISH) begin
        adc_out[ch*ADC_BITS +: ADC_BITS] <= pub_val;
        sample_valid[ch]                 <= 1'b1;
        round_done                       <= (ch == LAST_CH);
        acc                              <= '0;
        cnt                              <= '0;
        ch                               <= ch_wrap;
      end
    end
  end

endmodule
